koopa_anim_ctrl: RTL and testbench

Per-character animation controller directly upstream of the Koopa animation FSMs (idle, walk, air, neutral attack). It converts per-video-frame strobes into the shared `anim_tick` and picks the active animation from player inputs. It pulses a one-hot restart into the selected FSM on every animation change and muxes that FSM's `anim_row`/`anim_col` to the sprite renderer. It also enforces an attack lock, so a neutral attack always plays to completion before movement animations resume.

---
 rtl/koopa_anim_ctrl.sv | 165 ++++++++++++++++
 tb/tb_koopa_anim_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/koopa_anim_ctrl.sv
// Koopa animation controller: frame-strobe divider, animation selection with
// attack lock, one-hot child restarts and sprite coordinate mux.
module koopa_anim_ctrl #(
    parameter int TICK_DIV     = 4,
    parameter int ATTACK_TICKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        btn_attack,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        airborne,
    input  logic [10:0] idle_row,
    input  logic [10:0] idle_col,
    input  logic [10:0] walk_row,
    input  logic [10:0] walk_col,
    input  logic [10:0] air_row,
    input  logic [10:0] air_col,
    input  logic [10:0] atk_row,
    input  logic [10:0] atk_col,
    output logic        anim_tick,
    output logic [3:0]  anim_rst,
    output logic [1:0]  anim_sel,
    output logic        busy,
    output logic        facing_left,
    output logic [10:0] sprite_row,
    output logic [10:0] sprite_col
);

    // state     | meaning
    // ST_IDLE   | grounded, no single direction held
    // ST_WALK   | grounded, exactly one direction held
    // ST_AIR    | not grounded
    // ST_ATTACK | neutral attack playing, locked for ATTACK_TICKS ticks
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_AIR    = 2'd2,
        ST_ATTACK = 2'd3
    } state_t;

    localparam int LOCK_W = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;

    state_t              state;
    state_t              next_state;
    state_t              desired;
    logic [4:0]          div_cnt;
    logic [4:0]          div_next;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [LOCK_W-1:0]   lock_next;
    logic                btn_prev;
    logic                atk_edge;
    logic                dir_one;
    logic                lock_done;
    logic                state_chg;
    logic                tick_next;
    logic [3:0]          rst_next;
    logic                face_next;

    always_comb begin
        dir_one    = move_left ^ move_right;
        atk_edge   = btn_attack & ~btn_prev;
        lock_done  = anim_tick && (lock_cnt == LOCK_W'(ATTACK_TICKS - 1));
        desired    = airborne ? ST_AIR : (dir_one ? ST_WALK : ST_IDLE);
        next_state = state;
        state_chg  = 1'b0;
        rst_next   = 4'b0000;
        lock_next  = lock_cnt;
        div_next   = div_cnt;
        tick_next  = 1'b0;
        face_next  = facing_left;

        if (state == ST_ATTACK) begin
            if (lock_done) begin
                next_state = desired;
            end
        end else if (atk_edge) begin
            next_state = ST_ATTACK;
        end else begin
            next_state = desired;
        end

        state_chg = (next_state != state);
        if (state_chg) begin
            rst_next = 4'b0001 << next_state;
        end

        if (state_chg) begin
            lock_next = '0;
        end else if (state == ST_ATTACK && anim_tick) begin
            lock_next = lock_cnt + 1'b1;
        end

        // A frame strobe coinciding with a state change is dropped so the new
        // animation always starts on a full divider period.
        if (state_chg) begin
            div_next = 5'd0;
        end else if (frame_start) begin
            if (div_cnt == 5'(TICK_DIV - 1)) begin
                div_next  = 5'd0;
                tick_next = 1'b1;
            end else begin
                div_next = div_cnt + 5'd1;
            end
        end

        if (state != ST_ATTACK && dir_one) begin
            face_next = move_left;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= 5'd0;
            lock_cnt    <= '0;
            btn_prev    <= 1'b0;
            anim_tick   <= 1'b0;
            anim_rst    <= 4'b1111;
            facing_left <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            lock_cnt    <= lock_next;
            btn_prev    <= btn_attack;
            anim_tick   <= tick_next;
            anim_rst    <= rst_next;
            facing_left <= face_next;
        end
    end

    assign anim_sel = state;
    assign busy     = (state == ST_ATTACK);

    always_comb begin
        sprite_row = idle_row;
        sprite_col = idle_col;
        case (state)
            ST_WALK: begin
                sprite_row = walk_row;
                sprite_col = walk_col;
            end
            ST_AIR: begin
                sprite_row = air_row;
                sprite_col = air_col;
            end
            ST_ATTACK: begin
                sprite_row = atk_row;
                sprite_col = atk_col;
            end
            default: begin
                sprite_row = idle_row;
                sprite_col = idle_col;
            end
        endcase
    end

endmodule

// File: tb/tb_koopa_anim_ctrl.sv
// Scoreboard bench for koopa_anim_ctrl: directed scenarios then random traffic,
// all checked against a frame/tick counting model of the animation rules.
module tb_koopa_anim_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int ATTACK_TICKS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        btn_attack;
    logic        move_left;
    logic        move_right;
    logic        airborne;
    logic [10:0] idle_row, idle_col, walk_row, walk_col;
    logic [10:0] air_row, air_col, atk_row, atk_col;
    logic        anim_tick;
    logic [3:0]  anim_rst;
    logic [1:0]  anim_sel;
    logic        busy;
    logic        facing_left;
    logic [10:0] sprite_row, sprite_col;

    always #5 clk = ~clk;

    koopa_anim_ctrl #(.TICK_DIV(TICK_DIV), .ATTACK_TICKS(ATTACK_TICKS)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .btn_attack(btn_attack),
        .move_left(move_left), .move_right(move_right), .airborne(airborne),
        .idle_row(idle_row), .idle_col(idle_col), .walk_row(walk_row), .walk_col(walk_col),
        .air_row(air_row), .air_col(air_col), .atk_row(atk_row), .atk_col(atk_col),
        .anim_tick(anim_tick), .anim_rst(anim_rst), .anim_sel(anim_sel), .busy(busy),
        .facing_left(facing_left), .sprite_row(sprite_row), .sprite_col(sprite_col)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        busy;
        logic        tick;
        logic        face;
        logic [3:0]  rst;
        logic [10:0] row;
        logic [10:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tick_seen = 0;

    // Reference model: animation mode, frames counted since last (re)start,
    // ticks seen in the current attack.
    int m_mode = 0;
    int m_frames = 0;
    int m_atk_ticks = 0;
    bit m_tick = 0;
    bit m_prev_btn = 0;
    bit m_face = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    task automatic step();
        exp_t e;
        int   want_mode;
        int   nxt;
        bit   new_tick;
        idle_row = 11'($urandom); idle_col = 11'($urandom);
        walk_row = 11'($urandom); walk_col = 11'($urandom);
        air_row  = 11'($urandom); air_col  = 11'($urandom);
        atk_row  = 11'($urandom); atk_col  = 11'($urandom);
        e.rst = 4'h0;
        if (reset) begin
            m_mode = 0; m_frames = 0; m_atk_ticks = 0;
            m_tick = 0; m_prev_btn = 0; m_face = 0;
            e.rst = 4'hF;
        end else begin
            want_mode = airborne ? 2 : ((move_left != move_right) ? 1 : 0);
            if (m_mode == 3) begin
                if (m_tick) m_atk_ticks++;
                nxt = (m_atk_ticks == ATTACK_TICKS) ? want_mode : 3;
            end else begin
                nxt = (btn_attack && !m_prev_btn) ? 3 : want_mode;
            end
            if (m_mode != 3 && move_left != move_right) m_face = move_left;
            new_tick = 0;
            if (nxt != m_mode) begin
                m_frames = 0;
                m_atk_ticks = 0;
                e.rst = 4'(1 << nxt);
            end else if (frame_start) begin
                m_frames++;
                if (m_frames == TICK_DIV) begin
                    new_tick = 1;
                    m_frames = 0;
                end
            end
            m_prev_btn = btn_attack;
            m_mode = nxt;
            m_tick = new_tick;
        end
        e.sel  = 2'(m_mode);
        e.busy = (m_mode == 3);
        e.tick = m_tick;
        e.face = m_face;
        case (m_mode)
            1:       begin e.row = walk_row; e.col = walk_col; end
            2:       begin e.row = air_row;  e.col = air_col;  end
            3:       begin e.row = atk_row;  e.col = atk_col;  end
            default: begin e.row = idle_row; e.col = idle_col; end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            for (int j = 0; j < gap; j++) step();
        end
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (anim_tick === 1'b1) tick_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("anim_sel",    int'(anim_sel),    int'(e.sel));
                check("busy",        int'(busy),        int'(e.busy));
                check("anim_tick",   int'(anim_tick),   int'(e.tick));
                check("anim_rst",    int'(anim_rst),    int'(e.rst));
                check("facing_left", int'(facing_left), int'(e.face));
                check("sprite_row",  int'(sprite_row),  int'(e.row));
                check("sprite_col",  int'(sprite_col),  int'(e.col));
            end
        end
    end

    initial begin
        int t0;
        reset = 1'b1; frame_start = 1'b0; btn_attack = 1'b0;
        move_left = 1'b0; move_right = 1'b0; airborne = 1'b0;

        repeat (3) step();
        reset = 1'b0;
        step();
        t0 = tick_seen;
        frames(8, 1);
        check("ticks_after_8_frames", tick_seen - t0, 2);

        move_right = 1'b1;
        repeat (3) step();
        move_right = 1'b0; move_left = 1'b1;
        repeat (3) step();
        move_right = 1'b1;
        repeat (3) step();
        move_left = 1'b0;
        repeat (2) step();

        btn_attack = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            move_left = ~move_left;
            frames(1, 1);
        end
        repeat (3) step();

        btn_attack = 1'b0; step();
        btn_attack = 1'b1; step();
        frames(7 * TICK_DIV, 1);
        btn_attack = 1'b0; step();
        btn_attack = 1'b1; step();
        frames(9 * TICK_DIV + 2, 1);
        btn_attack = 1'b0;
        repeat (3) step();

        move_left = 1'b0; move_right = 1'b0;
        repeat (2) step();
        frames(3, 1);
        airborne = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        frames(6, 1);
        airborne = 1'b0;
        step();

        btn_attack = 1'b1; step();
        frames(10 * TICK_DIV, 1);
        reset = 1'b1; step();
        reset = 1'b0; step();
        frames(ATTACK_TICKS * TICK_DIV + 2, 1);
        btn_attack = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 3000; i++) begin
            frame_start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0)   btn_attack = ~btn_attack;
            if ($urandom_range(0, 9) == 0)   move_left  = ~move_left;
            if ($urandom_range(0, 9) == 0)   move_right = ~move_right;
            if ($urandom_range(0, 19) == 0)  airborne   = ~airborne;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; frame_start = 1'b0;
        repeat (2) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
